relm_fp_pack: RTL
=================

// Module: relm_fp_pack
// PURPOSE
// Multi-cycle normalise/round/pack stage: the consumer end of the custom-FP intermediate format
// (unnormalised mantissa in A, {sign,exp,inf,zero} in B) emitted by the FADD/FMUL/ISIGN ops.
// Accepts one operand pair, normalises it iteratively, applies round-to-nearest-even, flushes
// denormals, and returns an IEEE-754 single. Sits behind the custom unit as a coprocessor stage.
// PARAMETERS
// COARSE_SH  8    left-shift step (bits) used while in_m[30:30-COARSE_SH+1] region is all zero
// EXP_OFS    157  format offset: value = (-1)^s * m * 2^(e-EXP_OFS); m[30] set = normalised 1.f
// PORTS
// clk        in   1   clock
// rst_n      in   1   asynchronous active-low reset
// in_valid   in   1   operand present
// in_ready   out  1   block can accept (high only in IDLE)
// in_m       in   32  unsigned mantissa; bit0 is a sticky bit
// in_sign    in   1   sign
// in_exp     in   8   biased exponent in the format above
// in_inf     in   1   force infinity (with in_zero: NaN)
// in_zero    in   1   force zero (with in_inf: NaN)
// out_valid  out  1   result present, held until out_ready
// out_ready  in   1   downstream accepts
// out_f      out  32  IEEE-754 single result
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, out_valid=0, out_f=0; internal regs 0. Reset mid-op drops operand.
// - Transfer on in_valid&in_ready (IDLE) -> capture m, s, e as 10-bit signed {2'b00,in_exp}.
// - IDLE->OUT direct (1 cycle) for specials: inf&zero -> {s,8'hFF,1,22'd0}; inf -> {s,8'hFF,23'd0};
//   zero or m==0 -> {s,31'd0}. Otherwise IDLE->NORM.
// - NORM, one step per cycle: m[31]=1 -> m={0,m[31:2],m[1]|m[0]}, e+=1; else m[30:31-COARSE_SH]==0 ->
//   m<<=COARSE_SH, e-=COARSE_SH; else m[30]=0 -> m<<=1, e-=1; else (m[30]=1) -> ROUND.
//   Worst case m=1: 3 coarse + 6 fine steps; latency in_valid to out_valid <= 11 cycles.
// - ROUND (1 cycle): lsb=m[7], guard=m[6], sticky=|m[5:0]; up = guard&(sticky|lsb);
//   {c,f}=m[29:7]+up; c -> e+=1, f=0. Then e>=255 -> {s,8'hFF,23'd0}; e<=0 -> {s,31'd0}
//   (denormals flushed); else {s,e[7:0],f}. -> OUT.
// - OUT: out_valid=1, out_f stable; out_ready -> IDLE next cycle (out_valid=0, in_ready=1).
//   No bypass: new operand accepted no earlier than cycle after output handshake.
// - e is 10-bit signed throughout; never wraps (max 255+1, min 0-30).
// - out_ready while out_valid=0 ignored; in_valid outside IDLE ignored (in_ready=0).
// STRUCTURE
// - relm_fp_pkg: EXP_OFS, FP_EXP_INF=8'hFF, FP_QNAN_M=23'h400000, state encoding
//   {IDLE,NORM,ROUND,OUT}.
// - Sub-module relm_fp_round: combinational RNE + overflow/underflow pack of {s,e,m} -> out_f.
// - Top: FSM, operand regs, shifter step mux, handshake.
// TESTING
// - m=32'h40000000,e=157,s=0 -> out_f=32'h4E800000 (2^30), 2 cycles NORM/ROUND.
// - m=32'h00000001,e=157 -> 32'h3F800000; exactly 9 NORM shift cycles before ROUND.
// - RNE: e=127 m=32'h40000040 -> 32'h3F800000; m=32'h400000C0 -> 32'h3F800002;
//   m=32'h40000041 -> 32'h3F800001.
// - Overflow/underflow: m=32'hFFFFFFC0,e=253 -> round carry -> 32'h7F800000; m=32'h20000000,e=1 -> 32'h00000000.
// - Specials: inf=1 s=1 -> 32'hFF800000; inf=zero=1 -> 32'h7FC00000; zero=1 s=1 -> 32'h80000000;
//   each out_valid 1 cycle after accept.
// - Handshake/reset: hold out_ready=0 10 cycles -> out_f stable, in_ready=0; rst_n pulse during
//   NORM -> out_valid=0, in_ready=1 immediately, next operand processed correctly.

Source files
------------

// File: rtl/relm_fp_pkg.sv
// Shared constants and FSM encoding for the custom-FP normalise/round/pack stage.
// The intermediate format is value = (-1)^s * m * 2^(e-EXP_OFS), with m[30] marking a normalised 1.f.
package relm_fp_pkg;

    localparam int COARSE_SH_DEF = 8;
    localparam int EXP_OFS       = 157;
    // With m[30] as the hidden bit, IEEE biased exponent = e + (127 + 30 - EXP_OFS).
    localparam int EXP_ADJ       = 127 + 30 - EXP_OFS;

    localparam logic [7:0]  FP_EXP_INF = 8'hFF;
    localparam logic [22:0] FP_QNAN_M  = 23'h400000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/relm_fp_round.sv
// Combinational round-to-nearest-even plus overflow/underflow packing of a
// normalised {sign, exponent, mantissa} into an IEEE-754 single.
module relm_fp_round
    import relm_fp_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp,
    input  logic [29:0]       man,
    output logic [31:0]       f
);

    logic              lsb;
    logic              guard;
    logic              sticky;
    logic              up;
    logic [23:0]       sum;
    logic [22:0]       frac;
    logic signed [9:0] exp_r;

    always_comb begin
        lsb    = man[7];
        guard  = man[6];
        sticky = |man[5:0];
        up     = guard & (sticky | lsb);
        sum    = {1'b0, man[29:7]} + 24'(up);
        exp_r  = exp + $signed(10'(EXP_ADJ));
        frac   = sum[22:0];
        // Carry out of the fraction means the mantissa rolled over to 2.0.
        if (sum[23]) begin
            exp_r = exp_r + 10'sd1;
            frac  = '0;
        end
        if (exp_r >= 10'sd255) begin
            f = {sign, FP_EXP_INF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            f = {sign, 31'd0};
        end else begin
            f = {sign, exp_r[7:0], frac};
        end
    end

endmodule

// File: rtl/relm_fp_pack.sv
// Multi-cycle normalise/round/pack coprocessor stage: one operand at a time,
// iterative normalisation, RNE rounding, denormal flush, IEEE-754 single out.
module relm_fp_pack
    import relm_fp_pkg::*;
#(
    parameter int COARSE_SH = COARSE_SH_DEF
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_m,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic        in_inf,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_f,
    output state_t      dbg_state
);

    // Handshake: a transfer happens on a cycle where valid & ready are both high;
    // in_ready is high only in IDLE, out_valid only in OUT, and out_f is held until taken.
    state_t            state_q, state_d;
    logic [31:0]       m_q, m_d;
    logic              s_q, s_d;
    logic signed [9:0] e_q, e_d;
    logic [31:0]       f_q, f_d;
    logic [31:0]       round_f;
    logic              coarse_zero;

    relm_fp_round u_round (
        .sign (s_q),
        .exp  (e_q),
        .man  (m_q[29:0]),
        .f    (round_f)
    );

    assign coarse_zero = (m_q[30 -: COARSE_SH] == '0);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        e_d     = e_q;
        f_d     = f_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    m_d = in_m;
                    s_d = in_sign;
                    e_d = $signed({2'b00, in_exp});
                    if (in_inf && in_zero) begin
                        f_d     = {in_sign, FP_EXP_INF, FP_QNAN_M};
                        state_d = ST_OUT;
                    end else if (in_inf) begin
                        f_d     = {in_sign, FP_EXP_INF, 23'd0};
                        state_d = ST_OUT;
                    end else if (in_zero || (in_m == '0)) begin
                        f_d     = {in_sign, 31'd0};
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                // Right shift keeps bit 0 as a sticky OR so rounding still sees lost bits.
                if (m_q[31]) begin
                    m_d = {1'b0, m_q[31:2], m_q[1] | m_q[0]};
                    e_d = e_q + 10'sd1;
                end else if (coarse_zero) begin
                    m_d = m_q << COARSE_SH;
                    e_d = e_q - $signed(10'(COARSE_SH));
                end else if (!m_q[30]) begin
                    m_d = m_q << 1;
                    e_d = e_q - 10'sd1;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                f_d     = round_f;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            s_q     <= 1'b0;
            e_q     <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            e_q     <= e_d;
            f_q     <= f_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign out_f     = f_q;
    assign dbg_state = state_q;

endmodule
